int_div: RTL and testbench
==========================

// Module: int_div
// PURPOSE
//  Iterative restoring unsigned integer divider: quotient/remainder of a 64-bit dividend by a
//  32-bit divisor. Inverse companion of the mult/ISR arithmetic blocks; same start/done style
//  as mult, so datapath FSMs can use either unit interchangeably. Retires BITS_PER_CYCLE
//  quotient bits per clock.
// PARAMETERS
//  DIVIDEND_W      64  dividend and quotient width
//  DIVISOR_W       32  divisor and remainder width
//  BITS_PER_CYCLE  1   quotient bits per clock; must divide DIVIDEND_W (1,2,4,8 supported)
// PORTS
//  clock         in   1           single clock, rising edge
//  reset         in   1           asynchronous, active-high
//  start         in   1           request; sampled on a rising clock edge when accepted
//  dividend      in   DIVIDEND_W  unsigned, sampled with accepted start
//  divisor       in   DIVISOR_W   unsigned, sampled with accepted start
//  quotient      out  DIVIDEND_W  unsigned result, valid while done=1
//  remainder     out  DIVISOR_W   unsigned result, valid while done=1
//  done          out  1           level; high from completion until next accepted start
//  busy          out  1           high while iterating (state RUN)
//  div_by_zero   out  1           valid with done; 1 if the latched divisor was 0
// BEHAVIOUR
//  - Reset: state IDLE; quotient, remainder, done, busy, div_by_zero all 0; counter 0.
//  - FSM states IDLE, RUN, DONE. start accepted only in IDLE or DONE; ignored in RUN.
//  - Accept (IDLE/DONE & start): latch operands, clear done and div_by_zero.
//    divisor!=0 -> RUN, busy=1, count=N-1 where N=DIVIDEND_W/BITS_PER_CYCLE.
//    divisor==0 -> DONE next edge: quotient=all ones, remainder=dividend[DIVISOR_W-1:0],
//    div_by_zero=1 (latency 1 cycle).
//  - RUN step, per bit, MSB first: r' = {r, q_msb} (DIVISOR_W+1 bits); q shifted left;
//    if r' >= divisor then r = r' - divisor, new q lsb 1 else r = r'[DIVISOR_W-1:0], lsb 0.
//    Dividend and quotient share one shift register; partial remainder DIVISOR_W+1 bits wide.
//  - RUN with count==0 -> DONE: done=1, busy=0. Latency: start sampled at edge k, done
//    high after edge k+N (N=64 at defaults). quotient/remainder driven from registers,
//    held stable through DONE, must not show partial values while busy (hold last result
//    is not required: outputs may change once start is re-accepted).
//  - DONE & start -> immediately re-accept (back-to-back, no idle bubble); done drops
//    after that edge.
//  - Operand inputs are don't-care except on the accepting edge.
//  - reset asserted mid-RUN: abort immediately to reset values; no done pulse for the
//    aborted operation; next start after reset deasserts behaves normally.
//  - Invariant at done (divisor!=0): dividend == quotient*divisor + remainder,
//    remainder < divisor.
// STRUCTURE
//  - Package int_div_pkg: state enum (IDLE, RUN, DONE), localparam N, counter width
//    $clog2(N), DBZ quotient constant.
//  - Sub-module div_step: combinational single-bit restoring step
//    (in: r, q_msb, divisor; out: r_next, q_bit). int_div chains BITS_PER_CYCLE instances
//    per clock; FSM, counter and registers stay in int_div.
// TESTING
//  1. 100/7 -> after 64 cycles done=1, quotient=14, remainder=2, div_by_zero=0.
//  2. 64'hFFFF_FFFF_FFFF_FFFF/1 -> quotient all ones, remainder 0;
//     /32'hFFFF_FFFF -> quotient 64'h1_0000_0001, remainder 0.
//  3. 0/5 -> quotient 0, remainder 0; 5/9 -> quotient 0, remainder 5.
//  4. 12345/0 -> done one cycle after start, quotient all ones, remainder 12345,
//     div_by_zero=1.
//  5. start held during RUN with new operands -> ignored, first result correct;
//     start in DONE -> second result after 64 cycles, no bubble.
//  6. reset asserted 20 cycles into RUN -> all outputs 0 next; fresh 1000/3 gives 333 r 1.
//  Random: 10k pairs incl. BITS_PER_CYCLE=4 build, check invariant and latency N.

Source files
------------

// File: rtl/int_div_pkg.sv
// Shared types and constants for the iterative restoring divider.
// The defaults here describe the standard 64/32 build with one quotient bit per clock.
package int_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DIVIDEND_W_DEF     = 64;
    localparam int DIVISOR_W_DEF      = 32;
    localparam int BITS_PER_CYCLE_DEF = 1;

    localparam int N     = DIVIDEND_W_DEF / BITS_PER_CYCLE_DEF;
    localparam int CNT_W = $clog2(N);

    localparam logic [DIVIDEND_W_DEF-1:0] DBZ_QUOTIENT = '1;

    // A counter must be at least one bit wide, even when only one step is needed.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_div_step.sv
// One restoring-division step: shift in the next dividend bit, then subtract
// the divisor if the widened partial remainder is large enough.
module div_step #(
    parameter int DIVISOR_W = 32
) (
    input  logic [DIVISOR_W-1:0] r_i,
    input  logic                 q_msb_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W-1:0] r_next_o,
    output logic                 q_bit_o
);

    logic [DIVISOR_W:0]   r_ext;
    logic [DIVISOR_W-1:0] r_sub;
    logic                 sub_unused;

    // r_i < divisor, so r_ext < 2*divisor and the difference always fits in DIVISOR_W bits.
    assign r_ext               = {r_i, q_msb_i};
    assign {sub_unused, r_sub} = r_ext - {1'b0, divisor_i};
    assign q_bit_o             = (r_ext >= {1'b0, divisor_i});
    assign r_next_o            = q_bit_o ? r_sub : r_ext[DIVISOR_W-1:0];

endmodule

// File: rtl/int_div.sv
// Iterative unsigned divider with a start/done handshake; retires BITS_PER_CYCLE quotient bits per clock.
// Dividend and quotient share one shift register; results are copied to output registers on completion.
module int_div
    import int_div_pkg::*;
#(
    parameter int DIVIDEND_W     = DIVIDEND_W_DEF,
    parameter int DIVISOR_W      = DIVISOR_W_DEF,
    parameter int BITS_PER_CYCLE = BITS_PER_CYCLE_DEF
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic [DIVIDEND_W-1:0] quotient_o,
    output logic [DIVISOR_W-1:0]  remainder_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  div_by_zero_o
);

    localparam int STEPS  = DIVIDEND_W / BITS_PER_CYCLE;
    localparam int STEP_W = cnt_width(STEPS);

    state_e                 state_q, state_d;
    logic [STEP_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0]  shift_q, shift_d;
    logic [DIVISOR_W-1:0]   part_q, part_d;
    logic [DIVISOR_W-1:0]   dvsr_q, dvsr_d;
    logic [DIVIDEND_W-1:0]  quot_q, quot_d;
    logic [DIVISOR_W-1:0]   rem_q, rem_d;
    logic                   dbz_q, dbz_d;
    logic                   dvsr_zero;

    logic [DIVISOR_W-1:0]   r_chain [BITS_PER_CYCLE+1];
    logic [DIVIDEND_W-1:0]  q_chain [BITS_PER_CYCLE+1];

    assign r_chain[0] = part_q;
    assign q_chain[0] = shift_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        logic q_bit;

        div_step #(
            .DIVISOR_W (DIVISOR_W)
        ) u_step (
            .r_i       (r_chain[i]),
            .q_msb_i   (q_chain[i][DIVIDEND_W-1]),
            .divisor_i (dvsr_q),
            .r_next_o  (r_chain[i+1]),
            .q_bit_o   (q_bit)
        );

        assign q_chain[i+1] = {q_chain[i][DIVIDEND_W-2:0], q_bit};
    end

    assign dvsr_zero = (dvsr_q == '0);

    // A zero divisor passes through RUN for a single cycle so its result lands one edge
    // after acceptance, without ever raising busy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        part_d  = part_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = RUN;
                    shift_d = dividend_i;
                    part_d  = '0;
                    dvsr_d  = divisor_i;
                    dbz_d   = 1'b0;
                    cnt_d   = (divisor_i == '0) ? '0 : STEP_W'(STEPS - 1);
                end
            end
            RUN: begin
                if (dvsr_zero) begin
                    state_d = DONE;
                    quot_d  = DIVIDEND_W'(DBZ_QUOTIENT);
                    rem_d   = shift_q[DIVISOR_W-1:0];
                    dbz_d   = 1'b1;
                end else begin
                    shift_d = q_chain[BITS_PER_CYCLE];
                    part_d  = r_chain[BITS_PER_CYCLE];
                    if (cnt_q == '0) begin
                        state_d = DONE;
                        quot_d  = q_chain[BITS_PER_CYCLE];
                        rem_d   = r_chain[BITS_PER_CYCLE];
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            part_q  <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            part_q  <= part_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign done_o        = (state_q == DONE);
    assign busy_o        = (state_q == RUN) && !dvsr_zero;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_int_div.sv
// Self-checking bench for int_div: directed corner cases, handshake scenarios,
// reset abort and randomized operands against a plain-arithmetic reference.
module tb_int_div;

    localparam int BPC     = 1;
    localparam int N_LAT   = 64 / BPC;
    localparam int BOUND   = 200;
    localparam int N_RAND  = 400;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] dividend;
    logic [31:0] divisor;
    logic [63:0] quotient;
    logic [31:0] remainder;
    logic        done;
    logic        busy;
    logic        dbz;

    int checks   = 0;
    int failures = 0;

    int_div #(
        .DIVIDEND_W     (64),
        .DIVISOR_W      (32),
        .BITS_PER_CYCLE (BPC)
    ) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .start_i       (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .done_o        (done),
        .busy_o        (busy),
        .div_by_zero_o (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_quot(input logic [63:0] a, input logic [31:0] b);
        if (b == 32'd0) return 64'hFFFF_FFFF_FFFF_FFFF;
        return a / {32'd0, b};
    endfunction

    function automatic logic [31:0] ref_rem(input logic [63:0] a, input logic [31:0] b);
        logic [63:0] r;
        if (b == 32'd0) return a[31:0];
        r = a % {32'd0, b};
        return r[31:0];
    endfunction

    // Present operands with start for one accepting edge, then wait for done.
    task automatic run_op(input logic [63:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = $urandom;
        lat = 0;
        while (!done && lat < BOUND) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        #1;
        checks++;
        if ({quotient, remainder, done, busy, dbz} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got q=%h r=%h done=%b busy=%b dbz=%b, want all zero",
                     quotient, remainder, done, busy, dbz);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_directed;
        logic [63:0] va [6];
        logic [31:0] vb [6];
        int lat;
        int exp_lat;
        va[0] = 64'd100;                 vb[0] = 32'd7;
        va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 32'd1;
        va[2] = 64'hFFFF_FFFF_FFFF_FFFF; vb[2] = 32'hFFFF_FFFF;
        va[3] = 64'd0;                   vb[3] = 32'd5;
        va[4] = 64'd5;                   vb[4] = 32'd9;
        va[5] = 64'd12345;               vb[5] = 32'd0;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], lat);
            exp_lat = (vb[i] == 32'd0) ? 1 : N_LAT;
            checks++;
            if (lat !== exp_lat) begin
                failures++;
                $display("FAIL dir%0d_latency: got %0d cycles, want %0d", i, lat, exp_lat);
            end
            checks++;
            if (quotient !== ref_quot(va[i], vb[i]) || remainder !== ref_rem(va[i], vb[i])) begin
                failures++;
                $display("FAIL dir%0d_result: got q=%h r=%h, want q=%h r=%h", i, quotient, remainder,
                         ref_quot(va[i], vb[i]), ref_rem(va[i], vb[i]));
            end
            checks++;
            if (dbz !== (vb[i] == 32'd0)) begin
                failures++;
                $display("FAIL dir%0d_dbz: got %b, want %b", i, dbz, (vb[i] == 32'd0));
            end
        end
        // Result must hold while done stays high with no new start.
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || quotient !== 64'hFFFF_FFFF_FFFF_FFFF || remainder !== 32'd12345) begin
            failures++;
            $display("FAIL dir_hold: got done=%b q=%h r=%h, want 1 ffffffffffffffff 00003039",
                     done, quotient, remainder);
        end
    endtask

    task automatic test_start_during_run;
        int lat;
        @(negedge clk);
        start    = 1'b1;
        dividend = 64'd1000;
        divisor  = 32'd3;
        @(posedge clk);
        #1;
        dividend = 64'd7;
        divisor  = 32'd2;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b0;
        lat = 10;
        while (!done && lat < BOUND) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== N_LAT) begin
            failures++;
            $display("FAIL ignore_start_latency: got %0d cycles, want %0d", lat, N_LAT);
        end
        checks++;
        if (quotient !== 64'd333 || remainder !== 32'd1) begin
            failures++;
            $display("FAIL ignore_start_result: got q=%0d r=%0d, want q=333 r=1", quotient, remainder);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        run_op(64'd5000, 32'd13, lat);
        checks++;
        if (lat !== N_LAT || quotient !== 64'd384 || remainder !== 32'd8) begin
            failures++;
            $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d, want lat=%0d q=384 r=8",
                     lat, quotient, remainder, N_LAT);
        end
        // Start is raised in the same cycle done is first seen.
        start    = 1'b1;
        dividend = 64'hDEAD_BEEF_0123_4567;
        divisor  = 32'h0001_0003;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept: got done=%b busy=%b, want 0 1", done, busy);
        end
        lat = 0;
        while (!done && lat < BOUND) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== N_LAT) begin
            failures++;
            $display("FAIL b2b_latency: got %0d cycles, want %0d", lat, N_LAT);
        end
        checks++;
        if (quotient !== ref_quot(64'hDEAD_BEEF_0123_4567, 32'h0001_0003) ||
            remainder !== ref_rem(64'hDEAD_BEEF_0123_4567, 32'h0001_0003)) begin
            failures++;
            $display("FAIL b2b_second: got q=%h r=%h, want q=%h r=%h", quotient, remainder,
                     ref_quot(64'hDEAD_BEEF_0123_4567, 32'h0001_0003),
                     ref_rem(64'hDEAD_BEEF_0123_4567, 32'h0001_0003));
        end
    endtask

    task automatic test_reset_abort;
        int lat;
        int seen_done;
        @(negedge clk);
        start    = 1'b1;
        dividend = 64'd999_999;
        divisor  = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({quotient, remainder, done, busy, dbz} !== '0) begin
            failures++;
            $display("FAIL abort_outputs: got q=%h r=%h done=%b busy=%b dbz=%b, want all zero",
                     quotient, remainder, done, busy, dbz);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < N_LAT; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d cycles of done, want 0", seen_done);
        end
        run_op(64'd1000, 32'd3, lat);
        checks++;
        if (lat !== N_LAT || quotient !== 64'd333 || remainder !== 32'd1 || dbz !== 1'b0) begin
            failures++;
            $display("FAIL abort_fresh: got lat=%0d q=%0d r=%0d dbz=%b, want lat=%0d q=333 r=1 dbz=0",
                     lat, quotient, remainder, dbz, N_LAT);
        end
    endtask

    task automatic test_random;
        logic [63:0] a;
        logic [31:0] b;
        logic [63:0] eq;
        logic [31:0] er;
        logic [63:0] prev_q;
        logic [31:0] prev_r;
        logic [95:0] recon;
        int lat;
        int exp_lat;
        int unstable;
        prev_q = 64'd333;
        prev_r = 32'd1;
        for (int n = 0; n < N_RAND; n++) begin
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF - $urandom_range(0, 255);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = {32'd0, $urandom};
            else a = {$urandom, $urandom};
            eq = ref_quot(a, b);
            er = ref_rem(a, b);
            exp_lat = (b == 32'd0) ? 1 : N_LAT;

            @(negedge clk);
            start    = 1'b1;
            dividend = a;
            divisor  = b;
            @(posedge clk);
            #1;
            start    = 1'b0;
            dividend = {$urandom, $urandom};
            divisor  = $urandom;
            lat = 0;
            unstable = 0;
            while (!done && lat < BOUND) begin
                if (busy && (quotient !== prev_q || remainder !== prev_r)) unstable++;
                @(posedge clk);
                #1;
                lat++;
            end
            checks++;
            if (lat !== exp_lat || unstable !== 0) begin
                failures++;
                $display("FAIL rand%0d_timing: got lat=%0d unstable=%0d, want lat=%0d unstable=0",
                         n, lat, unstable, exp_lat);
            end
            checks++;
            if (quotient !== eq || remainder !== er || dbz !== (b == 32'd0)) begin
                failures++;
                $display("FAIL rand%0d_result: a=%h b=%h got q=%h r=%h dbz=%b, want q=%h r=%h dbz=%b",
                         n, a, b, quotient, remainder, dbz, eq, er, (b == 32'd0));
            end
            if (b != 32'd0) begin
                recon = {32'd0, quotient} * {64'd0, b} + {64'd0, remainder};
                checks++;
                if (recon !== {32'd0, a} || remainder >= b) begin
                    failures++;
                    $display("FAIL rand%0d_invariant: a=%h b=%h q*b+r=%h r=%h", n, a, b, recon, remainder);
                end
            end
            prev_q = eq;
            prev_r = er;
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_during_run();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
